// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction-store write path: loader FSM states,
// store geometry and the big-endian byte-lane mapping used by loader and memory.
package instruction_loader_pkg;

    localparam int WORD_BYTES        = 4;
    localparam int DEFAULT_MEM_BYTES = 512;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    // Byte at address offset 0 lives in word bits [31:24], offset 3 in [7:0].
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] offset);
        return word[8*(WORD_BYTES-1-int'(offset)) +: 8];
    endfunction

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Assembles four stream bytes MSB-first into one instruction word and flags
// the accept that completes it.
module byte_packer
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        complete
);

    logic [1:0] index;

    assign complete = accept && (index == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            index <= '0;
        end else if (clear) begin
            index <= '0;
        end else if (accept) begin
            word  <= {word[23:0], data};
            index <= index + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Byte-stream loader for the instruction store: packs bytes into big-endian words,
// writes them one per instruction and stalls the CPU for the whole session.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int MEM_BYTES  = DEFAULT_MEM_BYTES,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddress,
    input  logic [15:0]           wordCount,
    input  logic                  abort,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memWriteAddress,
    output logic [31:0]           memWriteData,
    output logic                  cpuStall,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            checksum
);

    localparam int SUM_W = ADDR_WIDTH + 2;

    state_t                state;
    logic [15:0]           remaining;
    logic [ADDR_WIDTH-1:0] start_aligned;
    logic [SUM_W-1:0]      end_addr;
    logic                  over_range;
    logic                  accept;
    logic                  word_done;
    logic                  pack_clear;

    // Two guard bits keep the end address from wrapping before the compare.
    assign start_aligned = {startAddress[ADDR_WIDTH-1:2], 2'b00};
    assign end_addr      = {2'b00, start_aligned} + {{(SUM_W-18){1'b0}}, wordCount, 2'b00};
    assign over_range    = end_addr > SUM_W'(MEM_BYTES);

    // Abort must win over a same-cycle accept or write, so it masks both strobes.
    assign byteReady      = (state == COLLECT) && !abort;
    assign memWriteEnable = (state == WRITE) && !abort;
    assign cpuStall       = (state != IDLE);
    assign accept         = byteValid && byteReady;
    assign pack_clear     = ((state == IDLE) && start) || (state == WRITE);

    byte_packer u_packer (
        .clk      (clock),
        .rst_n    (resetN),
        .clear    (pack_clear),
        .accept   (accept),
        .data     (byteIn),
        .word     (memWriteData),
        .complete (word_done)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state           <= IDLE;
            remaining       <= '0;
            memWriteAddress <= '0;
            checksum        <= '0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (over_range) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            error           <= 1'b0;
                            checksum        <= '0;
                            memWriteAddress <= start_aligned;
                            remaining       <= wordCount;
                            if (wordCount == 16'd0) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                state <= COLLECT;
                            end
                        end
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else if (accept) begin
                        checksum <= checksum + byteIn;
                        if (word_done) state <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        memWriteAddress <= memWriteAddress + ADDR_WIDTH'(WORD_BYTES);
                        remaining       <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: table of load sessions plus hand-written
// abort, reset and ignored-start sequences.
module tb_instruction_loader;

    logic        clock = 1'b0;
    logic        resetN;
    logic        start;
    logic [31:0] startAddress;
    logic [15:0] wordCount;
    logic        abort;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic        memWriteEnable;
    logic [31:0] memWriteAddress;
    logic [31:0] memWriteData;
    logic        cpuStall;
    logic        done;
    logic        error;
    logic [7:0]  checksum;

    instruction_loader dut (
        .clock           (clock),
        .resetN          (resetN),
        .start           (start),
        .startAddress    (startAddress),
        .wordCount       (wordCount),
        .abort           (abort),
        .byteIn          (byteIn),
        .byteValid       (byteValid),
        .byteReady       (byteReady),
        .memWriteEnable  (memWriteEnable),
        .memWriteAddress (memWriteAddress),
        .memWriteData    (memWriteData),
        .cpuStall        (cpuStall),
        .done            (done),
        .error           (error),
        .checksum        (checksum)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int done_cyc  = -1;
    bit prev_err  = 1'b0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    always begin
        @(negedge clock);
        #2;
        if (memWriteEnable) begin
            wr_addr.push_back(memWriteAddress);
            wr_data.push_back(memWriteData);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc = cyc;
    end

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [15:0] wc;
        logic [95:0] bytes;
        bit          toggle;
        bit          mid_start;
        bit          exp_err;
        logic [7:0]  exp_sum;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic begin_session(input logic [31:0] a, input logic [15:0] wc);
        @(negedge clock);
        start = 1'b1; startAddress = a; wordCount = wc;
        @(negedge clock);
        start = 1'b0; startAddress = '0; wordCount = '0;
    endtask

    // Called at a falling edge; returns at the falling edge after the last accept.
    task automatic feed(input logic [95:0] b, input int n);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 100) begin
            byteValid = 1'b1;
            byteIn = b[95-8*sent -: 8];
            #1;
            if (byteReady) sent++;
            guard++;
            @(negedge clock);
        end
        byteValid = 1'b0;
        chk("feed_budget", sent, n);
    endtask

    task automatic run_vec(input vec_t v);
        int  sent = 0;
        int  guard = 0;
        bit  phase = 1'b1;
        bit  stall_ok = 1'b1;
        bit  seen = 1'b0;
        int  nexp;
        logic [31:0] base;
        clear_log();
        @(negedge clock);
        chk({v.name, "/err_sticky"}, error, prev_err);
        start = 1'b1; startAddress = v.addr; wordCount = v.wc;
        @(negedge clock);
        start = 1'b0; startAddress = '0; wordCount = '0;
        #1;
        if (v.exp_err) begin
            chk({v.name, "/error"}, error, 1);
            chk({v.name, "/done"}, done, 1);
            chk({v.name, "/stall"}, cpuStall, 0);
            @(negedge clock); #1;
            chk({v.name, "/done_low"}, done, 0);
            chk({v.name, "/stall_low"}, cpuStall, 0);
            chk({v.name, "/err_hold"}, error, 1);
        end else if (v.wc == 16'd0) begin
            chk({v.name, "/stall"}, cpuStall, 1);
            chk({v.name, "/done"}, done, 1);
            chk({v.name, "/ready_low"}, byteReady, 0);
            @(negedge clock); #1;
            chk({v.name, "/idle"}, cpuStall, 0);
            chk({v.name, "/done_low"}, done, 0);
        end else begin
            chk({v.name, "/ready"}, byteReady, 1);
            while (sent < 4*int'(v.wc) && guard < 400) begin
                start = (v.mid_start && sent == 2);
                if (start) begin startAddress = 32'd0; wordCount = 16'd5; end
                byteValid = v.toggle ? phase : 1'b1;
                phase = !phase;
                byteIn = v.bytes[95-8*sent -: 8];
                #1;
                if (!cpuStall) stall_ok = 1'b0;
                if (byteValid && byteReady) sent++;
                guard++;
                @(negedge clock);
            end
            start = 1'b0; byteValid = 1'b0; startAddress = '0; wordCount = '0;
            chk({v.name, "/bytes_sent"}, sent, 4*int'(v.wc));
            #1;
            for (int i = 0; i < 10 && !seen; i++) begin
                if (done) seen = 1'b1;
                else begin
                    if (!cpuStall) stall_ok = 1'b0;
                    @(negedge clock); #1;
                end
            end
            chk({v.name, "/done_seen"}, seen, 1);
            chk({v.name, "/stall_held"}, stall_ok, 1);
            @(negedge clock); #1;
            chk({v.name, "/done_pulse"}, done, 0);
            chk({v.name, "/idle"}, cpuStall, 0);
            if (wr_cyc.size() > 0) chk({v.name, "/done_after_write"}, done_cyc - wr_cyc[$], 1);
        end
        nexp = v.exp_err ? 0 : int'(v.wc);
        base = {v.addr[31:2], 2'b00};
        chk({v.name, "/writes"}, wr_addr.size(), nexp);
        for (int i = 0; i < nexp && i < wr_addr.size(); i++) begin
            chk({v.name, "/addr"}, wr_addr[i], base + 32'(4*i));
            chk({v.name, "/data"}, wr_data[i], v.bytes[95-32*i -: 32]);
        end
        if (!v.exp_err) begin
            chk({v.name, "/checksum"}, checksum, v.exp_sum);
            chk({v.name, "/error_clear"}, error, 0);
        end
        prev_err = v.exp_err;
    endtask

    initial begin
        vecs[0] = '{"one_word",     32'd0,   16'd1,   96'h01004020_00000000_00000000, 1'b0, 1'b0, 1'b0, 8'h61};
        vecs[1] = '{"three_toggle", 32'd8,   16'd3,   96'h11223344_55667788_99AABBCC, 1'b1, 1'b0, 1'b0, 8'h2E};
        vecs[2] = '{"range_err",    32'd504, 16'd3,   96'h0,                          1'b0, 1'b0, 1'b1, 8'h00};
        vecs[3] = '{"end_508",      32'd508, 16'd1,   96'hDEADBEEF_00000000_00000000, 1'b0, 1'b0, 1'b0, 8'h38};
        vecs[4] = '{"zero_words",   32'd100, 16'd0,   96'h0,                          1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{"fill_to_512",  32'd500, 16'd3,   96'h01020304_05060708_090A0B0C, 1'b1, 1'b0, 1'b0, 8'h4E};
        vecs[6] = '{"over_by_word", 32'd0,   16'd129, 96'h0,                          1'b0, 1'b0, 1'b1, 8'h00};
        vecs[7] = '{"unaligned",    32'h0B,  16'd1,   96'hFFFFFFFF_00000000_00000000, 1'b0, 1'b0, 1'b0, 8'hFC};
        vecs[8] = '{"mid_start",    32'd200, 16'd2,   96'hA1A2A3A4_B1B2B3B4_00000000, 1'b0, 1'b1, 1'b0, 8'h54};

        resetN = 1'b0; start = 1'b0; startAddress = '0; wordCount = '0;
        abort = 1'b0; byteIn = '0; byteValid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset/stall", cpuStall, 0);
        chk("reset/ready", byteReady, 0);
        chk("reset/we", memWriteEnable, 0);
        chk("reset/done", done, 0);
        chk("reset/error", error, 0);
        chk("reset/addr", memWriteAddress, 0);
        chk("reset/data", memWriteData, 0);
        chk("reset/checksum", checksum, 0);
        @(negedge clock);
        resetN = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Abort after six bytes of a two-word session: only the first word lands.
        clear_log();
        begin_session(32'd32, 16'd2);
        feed(96'h10203040_50600000_00000000, 6);
        abort = 1'b1; byteValid = 1'b1; byteIn = 8'h77;
        #1;
        chk("abort/ready_masked", byteReady, 0);
        @(negedge clock);
        abort = 1'b0; byteValid = 1'b0;
        #1;
        chk("abort/done", done, 1);
        chk("abort/stall", cpuStall, 1);
        @(negedge clock); #1;
        chk("abort/idle", cpuStall, 0);
        chk("abort/writes", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            chk("abort/addr", wr_addr[0], 32'd32);
            chk("abort/data", wr_data[0], 32'h10203040);
        end
        chk("abort/checksum", checksum, 8'h50);

        // Abort landing on the write cycle suppresses that write.
        clear_log();
        begin_session(32'd0, 16'd2);
        feed(96'h10203040_00000000_00000000, 4);
        abort = 1'b1;
        #1;
        chk("abort_wr/we_masked", memWriteEnable, 0);
        @(negedge clock);
        abort = 1'b0;
        #1;
        chk("abort_wr/done", done, 1);
        @(negedge clock); #1;
        chk("abort_wr/writes", wr_addr.size(), 0);
        chk("abort_wr/checksum", checksum, 8'hA0);
        prev_err = 1'b0;

        run_vec(vecs[0]);

        // Asynchronous reset in the middle of COLLECT.
        clear_log();
        begin_session(32'd64, 16'd2);
        feed(96'h12340000_00000000_00000000, 2);
        #1;
        resetN = 1'b0;
        #1;
        chk("arst/stall", cpuStall, 0);
        chk("arst/ready", byteReady, 0);
        chk("arst/we", memWriteEnable, 0);
        chk("arst/done", done, 0);
        chk("arst/addr", memWriteAddress, 0);
        chk("arst/data", memWriteData, 0);
        chk("arst/checksum", checksum, 0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("arst/stays_idle", cpuStall, 0);
        chk("arst/writes", wr_addr.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
